// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: reset/invalid constants, buffer entry layout
// and the word-alignment helper used on every fetch address.
package if_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INVALID_INST     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } buf_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small synchronous FIFO with flush; the head entry is visible combinationally
// so decode sees a buffered instruction in the cycle after it is written.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches, tracks in-flight PCs, buffers
// returned instructions for decode and squashes stale responses on redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_take_branch_in,
  input  logic [31:0] ex_target_PC_in,
  input  logic        id_stall_in,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_id_valid_inst,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic [31:0] if_id_IR
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] squash_q, squash_d;
  logic          run_q;

  logic          pcq_full, pcq_empty;
  logic [CW-1:0] pcq_count;
  logic [31:0]   pcq_head;
  logic          buf_full, buf_empty, buf_pop;
  logic [CW-1:0] buf_count;
  buf_entry_t    buf_head, buf_in;

  logic [OW-1:0] occupancy;
  logic          req_fire, resp_live, resp_counted;

  assign if_id_valid_inst = !buf_empty && !ex_take_branch_in;
  assign buf_pop          = if_id_valid_inst && !id_stall_in;

  // Credit the head leaving this cycle so a steady stream runs without bubbles.
  assign occupancy      = OW'(pcq_count) + OW'(buf_count) - OW'(buf_pop);
  assign imem_req_valid = run_q && !rst && !ex_take_branch_in && (squash_q == '0)
                          && (occupancy < OW'(BUF_DEPTH));
  assign imem_req_addr  = word_align(pc_q);
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_counted = imem_resp_valid && (!pcq_empty || (squash_q != '0));
  assign resp_live    = imem_resp_valid && (squash_q == '0) && !pcq_empty;
  assign buf_in       = '{pc: pcq_head, ir: imem_resp_data};

  assign if_id_PC  = if_id_valid_inst ? buf_head.pc : 32'h0;
  assign if_id_NPC = if_id_valid_inst ? buf_head.pc + 32'd4 : 32'h0;
  assign if_id_IR  = if_id_valid_inst ? buf_head.ir : INVALID_INST;

  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(32)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (ex_take_branch_in),
    .push      (req_fire),
    .push_data (imem_req_addr),
    .pop       (resp_live),
    .head_data (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH($bits(buf_entry_t))) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (ex_take_branch_in),
    .push      (resp_live),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head_data (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // While squashing the PC queue is empty, so the sum never exceeds BUF_DEPTH.
  always_comb begin
    pc_d     = pc_q;
    squash_d = squash_q;
    if (ex_take_branch_in) begin
      pc_d     = word_align(ex_target_PC_in);
      squash_d = CW'(OW'(pcq_count) + OW'(squash_q) - OW'(resp_counted));
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (imem_resp_valid && (squash_q != '0)) squash_d = squash_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      squash_q <= '0;
      run_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      squash_q <= squash_d;
      run_q    <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (imem_resp_valid) begin
        assert (resp_counted) else $error("if_stage: response with nothing outstanding");
      end
      assert (!(req_fire && pcq_full && !resp_live)) else $error("if_stage: PC queue overflow");
      assert (!(resp_live && buf_full && !buf_pop)) else $error("if_stage: buffer overflow");
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a queue-based model of the
// fetch/squash/buffer rules and an in-order variable-latency memory.
module tb_if_stage;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_take_branch_in;
  logic [31:0] ex_target_PC_in;
  logic        id_stall_in;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_id_valid_inst;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_NPC;
  logic [31:0] if_id_IR;

  if_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(D)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_take_branch_in (ex_take_branch_in),
    .ex_target_PC_in   (ex_target_PC_in),
    .id_stall_in       (id_stall_in),
    .imem_req_valid    (imem_req_valid),
    .imem_req_addr     (imem_req_addr),
    .imem_req_ready    (imem_req_ready),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .if_id_valid_inst  (if_id_valid_inst),
    .if_id_PC          (if_id_PC),
    .if_id_NPC         (if_id_NPC),
    .if_id_IR          (if_id_IR)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: fetches in flight (live or squashed) and PCs waiting for decode.
  typedef struct {
    logic [31:0] pc;
    bit          live;
  } infl_t;
  infl_t       infl[$];
  logic [31:0] mbuf[$];
  logic [31:0] m_pc;
  bit          m_run;

  // Memory: in-order responses with per-request latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    last_due = 0;
  int    lat_min  = 1;
  int    lat_max  = 1;
  int    resp_cnt = 0;

  logic [31:0] dreq_log[$];
  logic [31:0] ddel_pc[$];
  int          ddel_cyc[$];
  logic        s_req_valid, s_valid;
  logic [31:0] s_req_addr, s_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0F00;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic br, input logic [31:0] tgt,
                      input logic stall, input logic rdy);
    bit    resp_v, exp_valid, exp_pop, exp_req, dead;
    int    occ, lat, d;
    mreq_t nreq;
    infl_t nent;
    @(negedge clk);
    rst               = r;
    ex_take_branch_in = br;
    ex_target_PC_in   = tgt;
    id_stall_in       = stall;
    imem_req_ready    = rdy;
    resp_v            = !r && (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_valid   = resp_v;
    imem_resp_data    = resp_v ? mem_data(mq[0].addr) : $urandom;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_valid     = if_id_valid_inst;
    s_pc        = if_id_PC;

    dead = 1'b0;
    foreach (infl[i]) if (!infl[i].live) dead = 1'b1;
    exp_valid = (mbuf.size() > 0) && !br;
    exp_pop   = exp_valid && !stall;
    occ       = infl.size() + mbuf.size() - (exp_pop ? 1 : 0);
    exp_req   = m_run && !br && !dead && (occ < D);

    if (!r) begin
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr, m_pc);
      chk("id_valid", 32'(if_id_valid_inst), 32'(exp_valid));
      chk("id_pc",  if_id_PC,  exp_valid ? mbuf[0] : 32'h0);
      chk("id_npc", if_id_NPC, exp_valid ? mbuf[0] + 32'd4 : 32'h0);
      chk("id_ir",  if_id_IR,  exp_valid ? mem_data(mbuf[0]) : 32'h0);
    end

    // Environment side, driven by what the DUT actually did.
    if (resp_v) begin
      mq.delete(0);
      resp_cnt++;
    end
    if (!r && imem_req_valid && rdy) begin
      dreq_log.push_back(imem_req_addr);
      lat = $urandom_range(lat_max, lat_min);
      d   = cyc + lat;
      if (d < last_due) d = last_due;
      last_due  = d;
      nreq.addr = imem_req_addr;
      nreq.due  = d;
      mq.push_back(nreq);
    end
    if (!r && if_id_valid_inst && !stall) begin
      ddel_pc.push_back(if_id_PC);
      ddel_cyc.push_back(cyc);
      $display("deliver cyc=%0d pc=%h npc=%h ir=%h", cyc, if_id_PC, if_id_NPC, if_id_IR);
    end
    if (r) begin
      mq.delete();
      last_due = 0;
    end

    // Model update at the clock edge.
    if (r) begin
      infl.delete();
      mbuf.delete();
      m_pc  = 32'h0000_0000;
      m_run = 1'b0;
    end else begin
      if (resp_v && infl.size() > 0) begin
        if (infl[0].live) mbuf.push_back(infl[0].pc);
        infl.delete(0);
      end
      if (exp_pop) mbuf.delete(0);
      if (exp_req && rdy) begin
        nent.pc   = m_pc;
        nent.live = 1'b1;
        infl.push_back(nent);
        m_pc = m_pc + 32'd4;
      end
      if (br) begin
        foreach (infl[i]) infl[i].live = 1'b0;
        mbuf.delete();
        m_pc = tgt & 32'hFFFF_FFFC;
      end
      m_run = 1'b1;
    end
    cyc++;
  endtask

  task automatic drain();
    lat_min = 1;
    lat_max = 1;
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int          n_req, n_del, r0, drops, cnt200;
    logic [31:0] held;
    logic        rr, rb, rs, ry;
    logic [31:0] rt;

    rst               = 1'b1;
    ex_take_branch_in = 1'b0;
    ex_target_PC_in   = 32'h0;
    id_stall_in       = 1'b0;
    imem_req_ready    = 1'b0;
    imem_resp_valid   = 1'b0;
    imem_resp_data    = 32'h0;
    m_pc              = 32'h0;
    m_run             = 1'b0;

    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    // First cycle out of reset: nothing requested, nothing presented.
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_req_valid", 32'(s_req_valid), 32'h0);
    chk("rst_id_valid",  32'(s_valid),     32'h0);
    chk("rst_id_pc",     s_pc,             32'h0);

    // Streaming fetch at latency 1.
    n_req = dreq_log.size();
    n_del = ddel_pc.size();
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("seq_req0", qget(dreq_log, n_req),     32'h0);
    chk("seq_req1", qget(dreq_log, n_req + 1), 32'h4);
    chk("seq_req2", qget(dreq_log, n_req + 2), 32'h8);
    chk("seq_del0", qget(ddel_pc, n_del),      32'h0);
    chk("seq_del1", qget(ddel_pc, n_del + 1),  32'h4);
    chk("seq_del2", qget(ddel_pc, n_del + 2),  32'h8);
    chk("seq_consec", (ddel_cyc.size() >= n_del + 3) ?
        32'(ddel_cyc[n_del + 2] - ddel_cyc[n_del]) : 32'hFFFF_FFFF, 32'd2);

    // Decode stall holds the head; release continues without loss.
    n_req = dreq_log.size();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    held = s_pc;
    chk("stall_valid", 32'(s_valid), 32'h1);
    repeat (4) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("stall_hold", s_pc, held);
    end
    chk("stall_nacc_le2", 32'((dreq_log.size() - n_req) <= 2), 32'h1);
    n_del = ddel_pc.size();
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("stall_rel0", qget(ddel_pc, n_del),     held);
    chk("stall_rel1", qget(ddel_pc, n_del + 1), held + 32'd4);
    chk("stall_rel2", qget(ddel_pc, n_del + 2), held + 32'd8);

    // Memory not ready: address holds, PC does not advance.
    drain();
    held = s_req_addr;
    chk("rdy_low_valid", 32'(s_req_valid), 32'h1);
    repeat (3) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("rdy_low_addr", s_req_addr, held);
    end
    n_req = dreq_log.size();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rdy_accept_addr", qget(dreq_log, n_req), held);

    // Redirect to a misaligned target with two fetches outstanding.
    drain();
    lat_min = 5;
    lat_max = 5;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("r36_outstanding", 32'(infl.size()), 32'd2);
    n_req = dreq_log.size();
    n_del = ddel_pc.size();
    r0    = resp_cnt;
    drops = -1;
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b1);
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      if (drops < 0 && dreq_log.size() > n_req) drops = resp_cnt - r0;
    end
    chk("r36_addr",     qget(dreq_log, n_req), 32'h0000_0100);
    chk("r36_drops",    32'(drops),            32'd2);
    chk("r36_first_pc", qget(ddel_pc, n_del),  32'h0000_0100);

    // Second redirect while the first squash is still pending.
    drain();
    lat_min = 4;
    lat_max = 4;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_del = ddel_pc.size();
    step(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1);
    lat_min = 1;
    lat_max = 1;
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cnt200 = 0;
    for (int i = n_del; i < ddel_pc.size(); i++)
      if (ddel_pc[i] >= 32'h200 && ddel_pc[i] < 32'h300) cnt200++;
    chk("r37_first_pc", qget(ddel_pc, n_del),     32'h0000_0300);
    chk("r37_second",   qget(ddel_pc, n_del + 1), 32'h0000_0304);
    chk("r37_no_200",   32'(cnt200),              32'h0);

    // Address wrap past the top of memory.
    drain();
    n_req = dreq_log.size();
    n_del = ddel_pc.size();
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("wrap_req0", qget(dreq_log, n_req),     32'hFFFF_FFF8);
    chk("wrap_req1", qget(dreq_log, n_req + 1), 32'hFFFF_FFFC);
    chk("wrap_req2", qget(dreq_log, n_req + 2), 32'h0000_0000);
    chk("wrap_del1", qget(ddel_pc, n_del + 1),  32'hFFFF_FFFC);
    chk("wrap_del2", qget(ddel_pc, n_del + 2),  32'h0000_0000);

    // Random traffic with stalls, back-pressure, redirects and resets.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(999) < 4);
      rb = ($urandom_range(99) < 5);
      rs = ($urandom_range(99) < 30);
      ry = ($urandom_range(99) < 75);
      rt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                    : ($urandom & 32'h0000_FFFF);
      step(rr, rb, rt, rs, ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
